bomberman_map_ctrl: RTL
=======================

Name: bomberman_map_ctrl

Overview:
- Command executor directly downstream of the AXI4-Lite register slave of the bomberman single-memory IP.
- The register slave decodes a software write into one command pulse. This block executes that command against the game tile-map RAM: write tile, read tile, clear map, or count tiles.
- It returns one response pulse, which the register slave latches into its status/readback registers.
- The map RAM is external, single-port and synchronous, with 1-cycle read latency.

Parameters:
- MAP_W, 16, columns per map; must be a power of 2.
- MAP_H, 12, rows per map; must be ≤ MAP_W.
- TILE_W, 4, bits per tile code.
- ADDR_W, 8, map RAM address width; must be ≥ log2(MAP_W) + log2(MAP_H).
- CNT_W, 8, width of the count result; must hold MAP_W*MAP_H.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe from the register slave
- cmd_ready  out  1  block is idle and accepts a command
- cmd_op  in  2  command code: 0 WRITE, 1 READ, 2 CLEAR, 3 COUNT
- cmd_x  in  4  column
- cmd_y  in  4  row
- cmd_tile  in  TILE_W  tile for WRITE; fill value for CLEAR; match value for COUNT
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  coordinate out of range; qualified by rsp_valid
- rsp_data  out  CNT_W  READ: tile, zero-extended; COUNT: match count; else 0
- busy  out  1  equals !cmd_ready
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address, computed as {y, x[log2(MAP_W)-1:0]}
- mem_wdata  out  TILE_W  RAM write data
- mem_rdata  in  TILE_W  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values: cmd_ready=1, busy=0, all other outputs 0, state IDLE, all counters 0. Reset asserted mid-operation aborts the command immediately: mem_en and mem_we drop asynchronously and no rsp_valid is issued.
- A command is accepted when cmd_valid & cmd_ready at a rising edge (cycle 0). The command fields are registered on acceptance. cmd_valid while busy is ignored; no queueing.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, SCAN, DRAIN, RESP.
- Range check (WRITE and READ only):
  - Out of range means cmd_x ≥ MAP_W or cmd_y ≥ MAP_H.
  - On out of range: IDLE→RESP with rsp_err=1 and rsp_data=0.
  - No RAM access occurs; rsp_valid is high in cycle 1.
- WRITE:
  - IDLE→WR. In cycle 1: mem_en=1, mem_we=1, mem_addr and mem_wdata driven.
  - WR→RESP; rsp_valid in cycle 2.
- READ:
  - IDLE→RD_ISSUE. In cycle 1: mem_en=1, mem_we=0.
  - RD_WAIT in cycle 2: mem_rdata is captured.
  - RESP: rsp_valid in cycle 3, rsp_data = the captured tile.
- CLEAR:
  - IDLE→SCAN. The scan counter walks row-major from (0,0) to (MAP_W-1, MAP_H-1), skipping nothing.
  - One write per cycle of cmd_tile, over cycles 1..N where N = MAP_W*MAP_H = 192.
  - After the last address: RESP; rsp_valid in cycle N+1.
- COUNT:
  - SCAN issues one read per cycle over cycles 1..N. Each mem_rdata is compared to cmd_tile one cycle later.
  - The match counter saturates at 2^CNT_W-1.
  - DRAIN (cycle N+1) evaluates the last read. RESP: rsp_valid in cycle N+2, rsp_data = count.
- Coordinates are ignored for CLEAR and COUNT.
- RESP lasts exactly 1 cycle, then returns to IDLE. cmd_ready is 1 in RESP+1, so back-to-back commands are separated by ≥1 idle cycle.
- mem_en=0 in IDLE, RESP and DRAIN. mem_we is never 1 outside WR and CLEAR-SCAN.
- rsp_err and rsp_data are held between pulses; they are cleared on the next acceptance.

Decomposition:
- Shared package bomberman_map_pkg holds:
  - the map_op_t enum (WRITE, READ, CLEAR, COUNT);
  - the state enum;
  - tile constants: TILE_EMPTY=0, TILE_WALL=1, TILE_BRICK=2, TILE_BOMB=3, TILE_FIRE=4, TILE_POWERUP=5;
  - MAP_W, MAP_H and the function addr_of(x, y).
- One sub-module, bomberman_map_scan: a row-major x/y scan counter with start, step, last and addr outputs. It is shared by CLEAR and COUNT.

Test Plan:
- WRITE (x=3, y=2, tile=2), then READ (3,2) → mem_addr=0x23 with mem_we=1 in cycle 1; the READ gives rsp_valid in cycle 3 with rsp_data=0x02 and rsp_err=0.
- WRITE (x=5, y=12) and READ (x=0, y=15) → rsp_valid in cycle 1 with rsp_err=1; mem_en stays 0 throughout.
- CLEAR tile=1 → exactly 192 write cycles, addresses 0x00..0xBF with no gaps; rsp_valid in cycle 193. A subsequent COUNT tile=1 → rsp_data=192 in cycle 194.
- After CLEAR tile=0, WRITE tile=3 at (0,0), (15,11) and (7,6); COUNT tile=3 → rsp_data=3. Corner addresses 0x00 and 0xBF are included in the scan.
- cmd_valid pulsed during a CLEAR → ignored: cmd_ready=0, no second response, and the scan is unaffected.
- ARESETN deasserted at scan cycle 50 of a CLEAR → mem_we drops immediately and no rsp_valid is issued. After release, cmd_ready=1 and a READ returns correctly.

Source files
------------

// File: rtl/bomberman_map_pkg.sv
// Shared types, tile codes and address helper for the bomberman tile-map command executor.
package bomberman_map_pkg;
  localparam int MAP_W = 16;
  localparam int MAP_H = 12;
  localparam int XW    = $clog2(MAP_W);

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_COUNT = 2'd3
  } map_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_SCAN,
    ST_DRAIN,
    ST_RESP
  } map_state_t;

  localparam logic [3:0] TILE_EMPTY   = 4'd0;
  localparam logic [3:0] TILE_WALL    = 4'd1;
  localparam logic [3:0] TILE_BRICK   = 4'd2;
  localparam logic [3:0] TILE_BOMB    = 4'd3;
  localparam logic [3:0] TILE_FIRE    = 4'd4;
  localparam logic [3:0] TILE_POWERUP = 4'd5;

  // Row-major packing: the row sits above the column bits, so no multiplier is needed.
  function automatic logic [XW+3:0] addr_of(input logic [3:0] x, input logic [3:0] y);
    return {y, x[XW-1:0]};
  endfunction
endpackage

// File: rtl/bomberman_map_scan.sv
// Row-major x/y walker over the whole map, shared by the CLEAR and COUNT sweeps.
module bomberman_map_scan #(
  parameter int MAP_W  = 16,
  parameter int MAP_H  = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);
  import bomberman_map_pkg::*;

  logic [3:0] x_q, x_d, y_q, y_d;
  logic       x_end;

  always_comb begin
    x_end = (x_q == 4'(MAP_W - 1));
    last  = x_end && (y_q == 4'(MAP_H - 1));
    x_d   = x_q;
    y_d   = y_q;
    if (start) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_q + 4'd1;
      end else begin
        x_d = x_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign addr = ADDR_W'(addr_of(x_q, y_q));
endmodule

// File: rtl/bomberman_map_ctrl.sv
// Executes one register-slave command (write/read/clear/count) against the single-port tile-map RAM.
module bomberman_map_ctrl #(
  parameter int MAP_W  = 16,
  parameter int MAP_H  = 12,
  parameter int TILE_W = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_x,
  input  logic [3:0]        cmd_y,
  input  logic [TILE_W-1:0] cmd_tile,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  rsp_data,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [TILE_W-1:0] mem_wdata,
  input  logic [TILE_W-1:0] mem_rdata
);
  import bomberman_map_pkg::*;

  map_state_t        state_q, state_d;
  map_op_t           op_q, op_d;
  logic [3:0]        x_q, x_d, y_q, y_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              pend_q, pend_d;
  logic              oor, scan_start, scan_step, scan_last;
  logic [ADDR_W-1:0] scan_addr;

  bomberman_map_scan #(
    .MAP_W  (MAP_W),
    .MAP_H  (MAP_H),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .start (scan_start),
    .step  (scan_step),
    .last  (scan_last),
    .addr  (scan_addr)
  );

  // A COUNT read issued last cycle returns its data now; the match counter saturates.
  always_comb begin
    cnt_inc = cnt_q;
    if (pend_q && (mem_rdata == tile_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_inc = cnt_q + CNT_W'(1);
  end

  always_comb begin
    oor        = (int'(cmd_x) >= MAP_W) || (int'(cmd_y) >= MAP_H);
    state_d    = state_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    tile_d     = tile_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_inc;
    pend_d     = 1'b0;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = map_op_t'(cmd_op);
          x_d        = cmd_x;
          y_d        = cmd_y;
          tile_d     = cmd_tile;
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          cnt_d      = '0;
          case (map_op_t'(cmd_op))
            OP_WRITE: begin
              state_d   = oor ? ST_RESP : ST_WR;
              rsp_err_d = oor;
            end
            OP_READ: begin
              state_d   = oor ? ST_RESP : ST_RD_ISSUE;
              rsp_err_d = oor;
            end
            default: begin
              state_d    = ST_SCAN;
              scan_start = 1'b1;
            end
          endcase
        end
      end
      ST_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(addr_of(x_q, y_q));
        mem_wdata = tile_q;
        state_d   = ST_RESP;
      end
      ST_RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = ADDR_W'(addr_of(x_q, y_q));
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rsp_data_d = CNT_W'(mem_rdata);
        state_d    = ST_RESP;
      end
      ST_SCAN: begin
        mem_en    = 1'b1;
        mem_we    = (op_q == OP_CLEAR);
        mem_addr  = scan_addr;
        mem_wdata = (op_q == OP_CLEAR) ? tile_q : '0;
        pend_d    = (op_q == OP_COUNT);
        if (scan_last) state_d = (op_q == OP_COUNT) ? ST_DRAIN : ST_RESP;
        else           scan_step = 1'b1;
      end
      ST_DRAIN: begin
        rsp_data_d = cnt_inc;
        state_d    = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
    end
  end

  // Command fields are only consumed after acceptance, so they need no reset.
  always_ff @(posedge ACLK) begin
    op_q   <= op_d;
    x_q    <= x_d;
    y_q    <= y_d;
    tile_q <= tile_d;
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
endmodule
